// File: rtl/direction_key_encoder.sv
// Debounces four active-low direction keys and issues one 2-bit move command
// per clean press over a valid/ready handshake.
module direction_key_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       move_ready,
  output logic [1:0] direction,
  output logic       move_valid,
  output logic       keys_conflict
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    OFFER        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] p_sync;
  logic [NKEYS-1:0] p_db_q, p_db_d;
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];

  state_t     state_q, state_d;
  logic [1:0] direction_q, direction_d;
  logic       move_valid_q, move_valid_d;
  logic       keys_conflict_q, keys_conflict_d;

  logic       one_hot;
  logic [1:0] code;

  assign p_sync = ~sync2_q;

  // Per-key debouncer: level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_comb begin
    p_db_d = p_db_q;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = '0;
      if (p_sync[i] != p_db_q[i]) begin
        if (CNT_W'(cnt_q[i] + CNT_W'(1)) == CNT_W'(DEBOUNCE_CYCLES)) begin
          p_db_d[i] = p_sync[i];
        end else begin
          cnt_d[i] = CNT_W'(cnt_q[i] + CNT_W'(1));
        end
      end
    end
  end

  assign one_hot = (p_db_q != '0) && ((p_db_q & (p_db_q - NKEYS'(1))) == '0);

  always_comb begin
    case (p_db_q)
      4'b0001: code = 2'b00;
      4'b0010: code = 2'b01;
      4'b0100: code = 2'b11;
      4'b1000: code = 2'b10;
      default: code = 2'b00;
    endcase
  end

  // Command FSM: one outstanding move, then wait for all keys released
  always_comb begin
    state_d         = state_q;
    direction_d     = direction_q;
    keys_conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          direction_d = code;
          state_d     = OFFER;
        end else if (p_db_q != '0) begin
          keys_conflict_d = 1'b1;
          state_d         = WAIT_RELEASE;
        end
      end
      OFFER: begin
        if (move_ready) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (p_db_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    move_valid_d = (state_d == OFFER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q         <= '1;
      sync2_q         <= '1;
      p_db_q          <= '0;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
      state_q         <= IDLE;
      direction_q     <= 2'b00;
      move_valid_q    <= 1'b0;
      keys_conflict_q <= 1'b0;
    end else begin
      sync1_q         <= key_n;
      sync2_q         <= sync1_q;
      p_db_q          <= p_db_d;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
      state_q         <= state_d;
      direction_q     <= direction_d;
      move_valid_q    <= move_valid_d;
      keys_conflict_q <= keys_conflict_d;
    end
  end

  assign direction     = direction_q;
  assign move_valid    = move_valid_q;
  assign keys_conflict = keys_conflict_q;

endmodule

// File: tb/tb_direction_key_encoder.sv
// Bench for direction_key_encoder: directed scenarios plus random key/ready
// traffic, every cycle compared against a behavioural model.
module tb_direction_key_encoder;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       move_ready;
  logic [1:0] direction;
  logic       move_valid;
  logic       keys_conflict;

  int checks = 0;
  int passed = 0;

  direction_key_encoder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .move_ready   (move_ready),
    .direction    (direction),
    .move_valid   (move_valid),
    .keys_conflict(keys_conflict)
  );

  always #5 clk = ~clk;

  // Model state: key sample pipeline, debounced levels, run lengths, command mode
  logic [3:0] m_s1, m_s2, m_pdb;
  int         m_run [4];
  int         m_mode;      // 0 idle, 1 offering, 2 waiting for release
  int         m_dir;
  int         m_conf;
  int         code_of [4] = '{0, 1, 3, 2};

  int  rises, conf_pulses, valid_at;
  logic prev_valid;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input logic [3:0] k, input logic rdy, input logic rs);
    int nset, idx;
    logic [3:0] pdb_new;
    if (rs) begin
      m_s1 = '1; m_s2 = '1; m_pdb = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode = 0; m_dir = 0; m_conf = 0;
      return;
    end
    m_conf = 0;
    nset = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (m_pdb[i]) begin nset++; idx = i; end
    case (m_mode)
      0: if (nset == 1) begin m_dir = code_of[idx]; m_mode = 1; end
         else if (nset > 1) begin m_conf = 1; m_mode = 2; end
      1: if (rdy) m_mode = 2;
      default: if (nset == 0) m_mode = 0;
    endcase
    pdb_new = m_pdb;
    for (int i = 0; i < 4; i++) begin
      if ((~m_s2[i]) != m_pdb[i]) begin
        m_run[i]++;
        if (m_run[i] >= int'(DB)) begin pdb_new[i] = ~m_pdb[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
    m_pdb = pdb_new;
    m_s2  = m_s1;
    m_s1  = k;
  endtask

  task automatic step(input logic [3:0] k, input logic rdy, input logic rs);
    key_n = k; move_ready = rdy; reset = rs;
    @(posedge clk);
    model_edge(k, rdy, rs);
    #1;
    check_eq("direction", int'(direction), m_dir);
    check_eq("move_valid", int'(move_valid), (m_mode == 1) ? 1 : 0);
    check_eq("keys_conflict", int'(keys_conflict), m_conf);
    if (move_valid && !prev_valid) rises++;
    if (keys_conflict) conf_pulses++;
    prev_valid = move_valid;
  endtask

  task automatic hold(input logic [3:0] k, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(k, rdy, 1'b0);
  endtask

  initial begin
    prev_valid = 1'b0;
    rises = 0; conf_pulses = 0;
    step(4'hF, 1'b1, 1'b1);
    check_eq("rst_direction", int'(direction), 0);
    check_eq("rst_valid", int'(move_valid), 0);
    check_eq("rst_conflict", int'(keys_conflict), 0);
    hold(4'hF, 1'b1, 3);

    // East press, ready tied high: one pulse, 6 edges after first low sample
    rises = 0; valid_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(4'b1101, 1'b1, 1'b0);
      if (move_valid && valid_at < 0) valid_at = i;
    end
    check_eq("east_latency", valid_at, int'(DB) + 2);
    check_eq("east_pulses", rises, 1);
    check_eq("east_dir", int'(direction), 1);
    hold(4'hF, 1'b1, 10);

    // Bouncing West, then a clean hold
    rises = 0;
    for (int r = 0; r < 5; r++) begin
      hold(4'b0111, 1'b1, 3);
      hold(4'b1111, 1'b1, 2);
    end
    check_eq("bounce_quiet", rises, 0);
    hold(4'b0111, 1'b1, 10);
    check_eq("bounce_pulses", rises, 1);
    check_eq("bounce_dir", int'(direction), 2);
    hold(4'hF, 1'b1, 10);

    // Backpressure on South; release while pending
    hold(4'b1011, 1'b0, 10);
    check_eq("bp_valid", int'(move_valid), 1);
    check_eq("bp_dir", int'(direction), 3);
    hold(4'hF, 1'b0, 10);
    check_eq("bp_pending", int'(move_valid), 1);
    step(4'hF, 1'b1, 1'b0);
    check_eq("bp_taken", int'(move_valid), 0);
    hold(4'hF, 1'b0, 4);

    // North+West together: conflict, no command
    rises = 0; conf_pulses = 0;
    hold(4'b0110, 1'b1, 10);
    check_eq("conf_pulses", conf_pulses, 1);
    check_eq("conf_no_cmd", rises, 0);
    check_eq("conf_dir_kept", int'(direction), 3);
    hold(4'hF, 1'b1, 10);
    hold(4'b1110, 1'b1, 10);
    check_eq("north_dir", int'(direction), 0);
    hold(4'hF, 1'b1, 10);

    // Staggered East then South
    rises = 0;
    hold(4'b1101, 1'b1, 2);
    hold(4'b1001, 1'b1, 15);
    check_eq("stag_pulses", rises, 1);
    check_eq("stag_dir", int'(direction), 1);
    hold(4'b1011, 1'b1, 10);
    check_eq("stag_east_rel", rises, 1);
    hold(4'hF, 1'b1, 10);
    hold(4'b1011, 1'b1, 10);
    check_eq("stag_south", int'(direction), 3);
    hold(4'hF, 1'b1, 10);

    // Reset while a command is pending, key held throughout
    hold(4'b1101, 1'b0, 10);
    step(4'b1101, 1'b0, 1'b1);
    check_eq("rst_offer_valid", int'(move_valid), 0);
    check_eq("rst_offer_dir", int'(direction), 0);
    rises = 0;
    hold(4'b1101, 1'b1, 15);
    check_eq("rst_offer_new", rises, 1);
    hold(4'hF, 1'b1, 10);

    // Random key/ready traffic with occasional reset
    for (int n = 0; n < 120; n++) begin
      logic [3:0] k;
      int len;
      k = 4'($urandom);
      if ($urandom_range(0, 2) == 0) k = 4'hF;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++)
        step(k, 1'($urandom), ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/direction_key_encoder.md
# direction_key_encoder

Front-end input controller for the adventure game. Debounces four active-low push-buttons and turns each clean press into exactly one 2-bit direction command. The command is offered to the room state machine with a valid/ready handshake. Sits between the board keys and the room FSM's `direction` input, and gates that FSM's moves so a held key never produces more than one move.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive clock cycles a synchronized key level must differ from its debounced value before the debounced value flips. Legal range 1..1023; counter width 10 bits.
- `clk`  input  1: single clock; all flops on rising edge.
- `reset`  input  1: synchronous, active-high; one clock, and reset is synchronous and active-high.
- `key_n`  input  4: raw buttons, active-low, asynchronous to `clk`. Bit mapping:
  - bit0 = North
  - bit1 = East
  - bit2 = South
  - bit3 = West
- `move_ready`  input  1: room FSM can accept a move this cycle.
- `direction`  output  2: command code. N=00, E=01, S=11, W=10. Held stable while `move_valid`=1. Holds the last issued code otherwise.
- `move_valid`  output  1: a command is being offered.
- `keys_conflict`  output  1: one-cycle pulse when a multi-key press is rejected.

## Operation
- Synchronizer: each `key_n` bit passes through a two-flop synchronizer, then is inverted to a pressed level `p_sync[i]` (1 = pressed).
- Debouncer, per key:
  - Holds a 10-bit counter and a debounced level `p_db[i]`.
  - Each cycle `p_sync[i]` != `p_db[i]`: counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`: `p_db[i]` flips and the counter clears.
  - Any cycle `p_sync[i]` == `p_db[i]`: counter clears.
  - Pulses shorter than `DEBOUNCE_CYCLES` cycles therefore never reach `p_db`.
- State machine, states IDLE, OFFER and WAIT_RELEASE:
  - IDLE:
    - `p_db` == 0000: stay.
    - `p_db` has exactly one bit set: latch the matching code into `direction` and go to OFFER.
    - `p_db` has two or more bits set: pulse `keys_conflict` for one cycle and go to WAIT_RELEASE. `direction` is unchanged.
  - OFFER:
    - `move_valid`=1.
    - The transfer occurs on the rising edge where `move_valid`=1 and `move_ready`=1. Next state is WAIT_RELEASE.
    - Releasing or adding keys while in OFFER does not cancel or alter the pending command.
  - WAIT_RELEASE:
    - `move_valid`=0.
    - Stay until `p_db` == 0000, then go to IDLE.
    - New presses are ignored until all keys read released.
- Only one command is ever outstanding; there is no queue.
- Encoded state, `move_valid` and `keys_conflict` are registered outputs. No combinational path from `key_n` or `move_ready` to any output.

## Timing
- Reset (`reset`=1 at an edge), values after that edge:
  - state=IDLE
  - `direction`=00
  - `move_valid`=0
  - `keys_conflict`=0
  - synchronizer flops=released (1)
  - `p_db`=0000
  - all counters=0
- Reset mid-OFFER: the pending command is dropped; `move_valid`=0 after the reset edge.
- Key held through reset: it debounces again and yields exactly one new command.
- Press latency: let edge k be the first edge sampling `key_n[i]`=0, with the key stable from then on.
  - `p_db[i]`=1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `move_valid`=1 after edge k+2+`DEBOUNCE_CYCLES`.
- Handshake:
  - `move_ready` already high when `move_valid` rises: transfer at the next edge, so `move_valid` is high exactly 1 cycle.
  - `move_ready` low: `move_valid` and `direction` hold indefinitely.
- Release latency: `p_db[i]` returns to 0 `DEBOUNCE_CYCLES`+1 edges after `key_n[i]` is first sampled high.
- Two keys whose `p_db` bits rise in the same cycle: conflict.
- Two keys whose `p_db` bits rise one or more cycles apart: the first wins; the second is ignored until a full release.
- `DEBOUNCE_CYCLES`=1 is legal: `p_db` follows `p_sync` with 1 cycle lag.

## Test plan
- Single press, `DEBOUNCE_CYCLES`=4, `move_ready` tied 1, `key_n`=1101 (East) held 20 cycles:
  - `move_valid` high for exactly 1 cycle, 6 edges after first low sample.
  - `direction`=01.
  - No further pulse until release and a new press.
- Bounce rejection: `key_n[3]` toggles low for 3 cycles, high for 2, repeated 5 times, then low 10 cycles:
  - no command during bouncing.
  - exactly one command, `direction`=10.
- Backpressure: `move_ready`=0, press South:
  - `move_valid`=1 and `direction`=11 held.
  - key released meanwhile; command still pending.
  - raise `move_ready` for 1 cycle: `move_valid` falls after that edge, state returns to IDLE.
- Conflict: North and West go low on the same cycle, held 10 cycles:
  - `keys_conflict` pulses once.
  - `move_valid` stays 0; `direction` keeps its prior value.
  - after full release, a lone North press yields `direction`=00.
- Staggered keys: East low, South low 2 cycles later, both held:
  - one command, `direction`=01.
  - releasing East only produces nothing.
  - releasing South, then pressing South, yields 11.
- Reset mid-OFFER: `move_ready`=0, command pending, `reset`=1 for 1 cycle, key still held:
  - outputs zero after the reset edge.
  - one new command appears 6 edges after the reset is deasserted.
